param_universal_shift_reg: RTL

Parametrised universal shift register, the next generation of the team's 4-bit universal shift register. It adds configurable width, rotate and arithmetic-shift modes, and serial outputs for chaining. A counted burst engine performs N shift/rotate steps from one start request, with a busy/done handshake. It sits in datapath and serialiser lab designs wherever a register must be loaded, shifted or rotated under control.

---
 rtl/shift_reg_pkg.sv | 24 ++
 rtl/shift_step_logic.sv | 31 +++
 rtl/param_universal_shift_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared mode codes, FSM state type and a mode classifier for the universal
// shift register family.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Modes that move bits and can therefore be repeated by the burst engine.
    function automatic logic is_step_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step_logic.sv
// Combinational next-value function of the register for one operation step;
// shared by the single-step and burst paths.
module shift_step_logic
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_load,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        next_q = q;
        case (mode)
            MODE_SHR:  next_q = {serial_in_left, q[WIDTH-1:1]};
            MODE_SHL:  next_q = {q[WIDTH-2:0], serial_in_right};
            MODE_LOAD: next_q = parallel_load;
            MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   next_q = q;
        endcase
    end

endmodule

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register with single-step control and a counted
// burst engine reporting busy/done.
module param_universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_load,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
);

    state_t           state, next_state;
    logic [2:0]       mode_lat, next_mode_lat;
    logic [CNT_W-1:0] remaining, next_remaining;
    logic [WIDTH-1:0] next_q, step_q;
    logic             next_busy, next_done;
    logic [2:0]       step_mode;

    // In a burst the latched mode drives the step; live mode is ignored.
    assign step_mode = (state == ST_BUSY) ? mode_lat : mode;

    shift_step_logic #(.WIDTH(WIDTH)) u_step (
        .q               (q),
        .mode            (step_mode),
        .serial_in_left  (serial_in_left),
        .serial_in_right (serial_in_right),
        .parallel_load   (parallel_load),
        .next_q          (step_q)
    );

    always_comb begin
        next_state     = state;
        next_mode_lat  = mode_lat;
        next_remaining = remaining;
        next_q         = q;
        next_busy      = 1'b0;
        next_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_mode_lat = mode;
                    if (is_step_mode(mode) && (count != '0)) begin
                        next_state     = ST_BUSY;
                        next_remaining = count;
                        next_busy      = 1'b1;
                    end else begin
                        // Degenerate request: completes at once, load is the only effect.
                        if (mode == MODE_LOAD) next_q = parallel_load;
                        next_done = 1'b1;
                    end
                end else if (en) begin
                    next_q = step_q;
                end
            end
            ST_BUSY: begin
                next_q         = step_q;
                next_remaining = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    next_state = ST_IDLE;
                    next_done  = 1'b1;
                end else begin
                    next_busy = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_lat  <= MODE_HOLD;
            remaining <= '0;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            mode_lat  <= next_mode_lat;
            remaining <= next_remaining;
            q         <= next_q;
            busy      <= next_busy;
            done      <= next_done;
        end
    end

    assign serial_out_left  = q[WIDTH-1];
    assign serial_out_right = q[0];

endmodule
